univ_shift_reg: RTL and testbench

//  Parametrised universal shift register that succeeds the fixed 4-bit serial-in serial-out register.
//  - Configurable width.
//  - Four modes: hold, shift-left, shift-right, parallel load.
//  - Registered serial outputs at both ends.
//  - Bit counter that pulses word_done after every WIDTH shifts.
//  - Serves as the common serializer/deserializer stage in the serial datapath blocks.
//

---
 rtl/usr_pkg.sv | 9 +
 rtl/usr_bit_counter.sv | 24 ++
 rtl/univ_shift_reg.sv | 60 ++++++
 tb/tb_univ_shift_reg.sv | 133 +++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: mode encodings shared by the universal shift register and its counter
package usr_pkg;
  typedef enum logic [1:0] {
    USR_HOLD = 2'b00,
    USR_SHL  = 2'b01,
    USR_SHR  = 2'b10,
    USR_LOAD = 2'b11
  } usr_mode_e;
endpackage

// File: rtl/usr_bit_counter.sv
// usr_bit_counter: counts shifts within a word, wraps at WIDTH-1 and emits a registered done pulse
module usr_bit_counter #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  logic last;
  assign last = cnt == CNT_W'(WIDTH - 1);
  // load clears the count, shifts advance and wrap; done marks only the completing shift
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      cnt  <= clr ? '0 : shift ? (last ? '0 : cnt + 1'b1) : cnt;
      done <= shift && !clr && last;
    end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register (hold/shl/shr/load); USR_ROTATE_EN adds rotate
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] par_in,
`ifdef USR_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] par_out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done
);
  logic [WIDTH-1:0] q, q_next;
  logic shl, shr, ld, rot, lsb_in, msb_in;
`ifdef USR_ROTATE_EN
  assign rot = rotate;
`else
  assign rot = 1'b0;
`endif
  assign shl = en && mode == USR_SHL;
  assign shr = en && mode == USR_SHR;
  assign ld  = en && mode == USR_LOAD;
  assign par_out = q;
  // serial entry bits come from the inputs or, when rotating, from the opposite end
  always_comb begin
    lsb_in = rot ? q[WIDTH-1] : sin_lsb;
    msb_in = rot ? q[0] : sin_msb;
    q_next = ld ? par_in : shl ? {q[WIDTH-2:0], lsb_in} : shr ? {msb_in, q[WIDTH-1:1]} : q;
  end
  // register contents plus the registered serial outputs at each end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q        <= '0;
      sout_msb <= 1'b0;
      sout_lsb <= 1'b0;
    end else begin
      q        <= q_next;
      sout_msb <= shl ? q[WIDTH-1] : sout_msb;
      sout_lsb <= shr ? q[0] : sout_lsb;
    end
  usr_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ld),
    .shift (shl || shr),
    .cnt   (bit_cnt),
    .done  (word_done)
  );
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scoreboard bench for univ_shift_reg (WIDTH=4); define USR_ROTATE_EN to cover rotate
module tb_univ_shift_reg;
  import usr_pkg::*;
  typedef struct {
    string      nm;
    logic [8:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic sin_lsb = 1'b0;
  logic sin_msb = 1'b0;
  logic [3:0] par_in = 4'b0000;
`ifdef USR_ROTATE_EN
  logic rotate = 1'b0;
`endif
  logic [3:0] par_out;
  logic sout_msb, sout_lsb, word_done;
  logic [1:0] bit_cnt;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  univ_shift_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sin_lsb   (sin_lsb),
    .sin_msb   (sin_msb),
    .par_in    (par_in),
`ifdef USR_ROTATE_EN
    .rotate    (rotate),
`endif
    .par_out   (par_out),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] ev(input logic [3:0] q, input logic ms, input logic ls,
                                    input logic [1:0] c, input logic d);
    return {q, ms, ls, c, d};
  endfunction
  // outputs change on every clock edge and on reset assertion; check the oldest expectation then
  always @(posedge clk or posedge reset) begin
    exp_t x;
    logic [8:0] got;
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      got = {par_out, sout_msb, sout_lsb, bit_cnt, word_done};
      total++;
      if (got !== x.v) begin
        bad++;
        $display("FAIL %s: got q=%b msb=%b lsb=%b cnt=%0d done=%b, want q=%b msb=%b lsb=%b cnt=%0d done=%b",
                 x.nm, got[8:5], got[4], got[3], got[2:1], got[0],
                 x.v[8:5], x.v[4], x.v[3], x.v[2:1], x.v[0]);
      end
    end
  end
  task automatic step(input string nm, input logic e, input logic [1:0] m, input logic sl,
                      input logic sm, input logic [3:0] pi, input logic ro, input logic [8:0] x);
    @(negedge clk);
    reset = 1'b0;
    en = e;
    mode = m;
    sin_lsb = sl;
    sin_msb = sm;
    par_in = pi;
`ifdef USR_ROTATE_EN
    rotate = ro;
`else
    if (ro) $display("note: rotate step issued without rotate support");
`endif
    sb.push_back('{nm, x});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    step("reset_state", 0, USR_HOLD, 0, 0, 4'b0000, 0, ev(4'b0000, 0, 0, 0, 0));
    step("pre_load",    1, USR_LOAD, 0, 0, 4'b1010, 0, ev(4'b1010, 0, 0, 0, 0));
    step("pre_shl1",    1, USR_SHL,  1, 0, 4'b0000, 0, ev(4'b0101, 1, 0, 1, 0));
    step("pre_shl2",    1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b1010, 0, 0, 2, 0));
    @(negedge clk);
    en = 1'b0;
    sb.push_back('{"reset_async", ev(4'b0000, 0, 0, 0, 0)});
    reset = 1'b1;
    step("after_reset", 0, USR_HOLD, 0, 0, 4'b0000, 0, ev(4'b0000, 0, 0, 0, 0));
    step("t2_load",  1, USR_LOAD, 0, 0, 4'b1011, 0, ev(4'b1011, 0, 0, 0, 0));
    step("t2_shl1",  1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b0110, 1, 0, 1, 0));
    step("t2_shl2",  1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b1100, 0, 0, 2, 0));
    step("t2_shl3",  1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b1000, 1, 0, 3, 0));
    step("t2_shl4",  1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b0000, 1, 0, 0, 1));
    step("t3_shr1",  1, USR_SHR,  0, 1, 4'b0000, 0, ev(4'b1000, 1, 0, 1, 0));
    step("t3_shr2",  1, USR_SHR,  0, 1, 4'b0000, 0, ev(4'b1100, 1, 0, 2, 0));
    for (int i = 0; i < 3; i++)
      step("t4_en_off", 0, USR_LOAD, 1, 1, 4'b1111, 0, ev(4'b1100, 1, 0, 2, 0));
    step("t5_load",  1, USR_LOAD, 0, 0, 4'b0101, 0, ev(4'b0101, 1, 0, 0, 0));
    step("t5_shl1",  1, USR_SHL,  1, 0, 4'b0000, 0, ev(4'b1011, 0, 0, 1, 0));
    step("t5_shl2",  1, USR_SHL,  1, 0, 4'b0000, 0, ev(4'b0111, 1, 0, 2, 0));
    step("t5_shl3",  1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b1110, 0, 0, 3, 0));
    step("t5_shl4",  1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b1100, 1, 0, 0, 1));
    step("t5_shl5",  1, USR_SHL,  1, 0, 4'b0000, 0, ev(4'b1001, 1, 0, 1, 0));
    step("t5_shl6",  1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b0010, 1, 0, 2, 0));
    step("t5_shl7",  1, USR_SHL,  1, 0, 4'b0000, 0, ev(4'b0101, 0, 0, 3, 0));
    step("t5_shl8",  1, USR_SHL,  1, 0, 4'b0000, 0, ev(4'b1011, 0, 0, 0, 1));
    step("hold",     1, USR_HOLD, 1, 1, 4'b1111, 0, ev(4'b1011, 0, 0, 0, 0));
    step("abort_shl",  1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b0110, 1, 0, 1, 0));
    step("abort_load", 1, USR_LOAD, 0, 0, 4'b1111, 0, ev(4'b1111, 1, 0, 0, 0));
    step("mix_shl1", 1, USR_SHL,  0, 0, 4'b0000, 0, ev(4'b1110, 1, 0, 1, 0));
    step("mix_shr1", 1, USR_SHR,  0, 0, 4'b0000, 0, ev(4'b0111, 1, 0, 2, 0));
    step("mix_shl2", 1, USR_SHL,  1, 0, 4'b0000, 0, ev(4'b1111, 0, 0, 3, 0));
    step("mix_shr2", 1, USR_SHR,  0, 0, 4'b0000, 0, ev(4'b0111, 0, 1, 0, 1));
    step("mix_after", 1, USR_HOLD, 0, 0, 4'b0000, 0, ev(4'b0111, 0, 1, 0, 0));
`ifdef USR_ROTATE_EN
    step("rot_load", 1, USR_LOAD, 0, 0, 4'b1000, 0, ev(4'b1000, 0, 1, 0, 0));
    step("rot_shl",  1, USR_SHL,  0, 0, 4'b0000, 1, ev(4'b0001, 1, 1, 1, 0));
    step("rot_shr",  1, USR_SHR,  0, 0, 4'b0000, 1, ev(4'b1000, 1, 1, 2, 0));
`endif
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
